rrarb8: RTL

- Eight-requester round-robin arbiter that shares one downstream resource, such as a bus or a datapath port.
- Produces a registered one-hot grant and its 3-bit binary code.
- Each grant is held until the owner drops its request or a hold limit expires.
- Fairness comes from a rotating priority pointer; within one arbitration the search is a circular priority encode starting at the pointer.

---
 rtl/rrarb8.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/rrarb8.sv
// Eight-requester round-robin arbiter with registered one-hot grant, binary code
// and a per-owner hold limit that forces re-arbitration when others are waiting.
module rrarb8 #(
   parameter int MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   output logic [7:0] gnt,
   output logic [2:0] gnt_code,
   output logic       gnt_valid
);

   localparam int CNT_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
   localparam bit HOLD_EN = (MAX_HOLD > 0);
   localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : {CNT_W{1'b0}};

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } state_t;

   state_t           state_r, state_s;
   logic [7:0]       gnt_r, gnt_s;
   logic [2:0]       code_r, code_s;
   logic             valid_r, valid_s;
   logic [2:0]       ptr_r, ptr_s;
   logic [CNT_W-1:0] hold_r, hold_s;

   logic [7:0]  cand_s;
   logic [15:0] dbl_s;
   logic [7:0]  rot_s;
   logic [2:0]  off_s;
   logic [2:0]  win_s;
   logic        found_s;
   logic        own_req_s;
   logic        limit_s;

   // Lowest set bit of an already-rotated mask; index is relative to the pointer.
   function automatic logic [2:0] lsb_index(input logic [7:0] v);
      logic [2:0] idx;
      casez (v)
         8'b???????1: idx = 3'd0;
         8'b??????10: idx = 3'd1;
         8'b?????100: idx = 3'd2;
         8'b????1000: idx = 3'd3;
         8'b???10000: idx = 3'd4;
         8'b??100000: idx = 3'd5;
         8'b?1000000: idx = 3'd6;
         8'b10000000: idx = 3'd7;
         default:     idx = 3'd0;
      endcase
      return idx;
   endfunction

   // Rotate-then-encode search: the doubled vector shifted by ptr puts ptr at bit 0.
   always_comb begin
      if (state_r == ST_OWN) begin
         cand_s = req & ~gnt_r;
      end else begin
         cand_s = req;
      end
      dbl_s     = {cand_s, cand_s} >> ptr_r;
      rot_s     = dbl_s[7:0];
      off_s     = lsb_index(rot_s);
      win_s     = off_s + ptr_r;
      found_s   = |cand_s;
      own_req_s = req[code_r];
      limit_s   = HOLD_EN && (hold_r == HOLD_LAST);
   end

   // Next-state and next-grant selection.
   always_comb begin
      state_s = state_r;
      gnt_s   = gnt_r;
      code_s  = code_r;
      ptr_s   = ptr_r;
      hold_s  = hold_r;
      case (state_r)
         ST_IDLE: begin
            if (found_s) begin
               state_s = ST_OWN;
               gnt_s   = 8'd1 << win_s;
               code_s  = win_s;
               ptr_s   = win_s + 3'd1;
               hold_s  = {CNT_W{1'b0}};
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_OWN: begin
            if (own_req_s && !limit_s) begin
               hold_s = hold_r + CNT_W'(1);
            end else if (found_s) begin
               gnt_s  = 8'd1 << win_s;
               code_s = win_s;
               ptr_s  = win_s + 3'd1;
               hold_s = {CNT_W{1'b0}};
            end else if (own_req_s) begin
               // Timed out with nobody else waiting: restart the hold, keep the pointer.
               hold_s = {CNT_W{1'b0}};
            end else begin
               state_s = ST_IDLE;
               gnt_s   = 8'd0;
               code_s  = 3'd0;
               hold_s  = {CNT_W{1'b0}};
            end
         end
         default: begin
            state_s = ST_IDLE;
            gnt_s   = 8'd0;
            code_s  = 3'd0;
            ptr_s   = 3'd0;
            hold_s  = {CNT_W{1'b0}};
         end
      endcase
      valid_s = |gnt_s;
   end

   // State, pointer, hold counter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         gnt_r   <= 8'd0;
         code_r  <= 3'd0;
         valid_r <= 1'b0;
         ptr_r   <= 3'd0;
         hold_r  <= {CNT_W{1'b0}};
      end else begin
         state_r <= state_s;
         gnt_r   <= gnt_s;
         code_r  <= code_s;
         valid_r <= valid_s;
         ptr_r   <= ptr_s;
         hold_r  <= hold_s;
      end
   end

   assign gnt       = gnt_r;
   assign gnt_code  = code_r;
   assign gnt_valid = valid_r;

endmodule
